// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: walks the full raster, drives pixel_x/pixel_y to
// the pixel memory and registers masked colour plus syncs onto the board pins.
module vga_scan_driver #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIX_DIV   = 4,
  parameter int SYNC_POL  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  input  logic [11:0] rgb_in,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        visible,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // 11-bit bounds so sync ends equal to 1024 still compare correctly
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SS   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SE   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SS   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SE   = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic [9:0]       h_nxt_s;
  logic [9:0]       v_nxt_s;
  logic [10:0]      hx_s;
  logic [10:0]      vy_s;
  logic             tick_s;
  logic             act_s;
  logic             hs_s;
  logic             vs_s;
  logic             fs_s;
  logic [11:0]      rgb_s;

  assign pixel_x = h_cnt_r;
  assign pixel_y = v_cnt_r;

  // Pixel tick, next raster position and pin values for the current position
  always_comb begin
    tick_s    = (div_cnt_r == DIV_LAST);
    hx_s      = {1'b0, h_cnt_r};
    vy_s      = {1'b0, v_cnt_r};
    act_s     = (hx_s < H_VIS) && (vy_s < V_VIS);
    hs_s      = ((hx_s >= H_SS) && (hx_s < H_SE)) ? SYNC_ON : SYNC_OFF;
    vs_s      = ((vy_s >= V_SS) && (vy_s < V_SE)) ? SYNC_ON : SYNC_OFF;
    fs_s      = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    rgb_s     = act_s ? rgb_in : 12'h000;
    div_nxt_s = tick_s ? DIV_ZERO : (div_cnt_r + DIV_ONE);
    h_nxt_s   = h_cnt_r;
    v_nxt_s   = v_cnt_r;
    if (tick_s) begin
      if (hx_s == H_LAST) begin
        h_nxt_s = 10'd0;
        v_nxt_s = (vy_s == V_LAST) ? 10'd0 : (v_cnt_r + 10'd1);
      end else begin
        h_nxt_s = h_cnt_r + 10'd1;
        v_nxt_s = v_cnt_r;
      end
    end else begin
      h_nxt_s = h_cnt_r;
      v_nxt_s = v_cnt_r;
    end
  end

  // Raster counters and pin registers; pins lag the counters by one tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r   <= DIV_ZERO;
      h_cnt_r     <= 10'd0;
      v_cnt_r     <= 10'd0;
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      visible     <= 1'b0;
      frame_start <= 1'b0;
      vga_hs      <= SYNC_OFF;
      vga_vs      <= SYNC_OFF;
    end else if (!en) begin
      div_cnt_r   <= DIV_ZERO;
      h_cnt_r     <= 10'd0;
      v_cnt_r     <= 10'd0;
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      visible     <= 1'b0;
      frame_start <= 1'b0;
      vga_hs      <= SYNC_OFF;
      vga_vs      <= SYNC_OFF;
    end else begin
      div_cnt_r   <= div_nxt_s;
      h_cnt_r     <= h_nxt_s;
      v_cnt_r     <= v_nxt_s;
      // frame_start drops on the clk after the (0,0) tick even when ticks are sparse
      frame_start <= tick_s & fs_s;
      if (tick_s) begin
        {vga_r, vga_g, vga_b} <= rgb_s;
        visible <= act_s;
        vga_hs  <= hs_s;
        vga_vs  <= vs_s;
      end
    end
  end

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
- VGA raster timing generator and output stage: the scanning end of the pixel-coordinate/colour interface.
- Walks the full raster, including blanking, with 10-bit horizontal and vertical counters and drives pixel_x/pixel_y to the pseudo-memory.
- Samples the 12-bit colour returned combinationally by the pseudo-memory, masks it during blanking, and registers it, aligned with hsync/vsync, onto the board VGA pins.
- Sits between the PMEM block and the top-level VGA connector.

Parameters:
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- PIX_DIV, 4: clk cycles per pixel (100 MHz to 25 MHz); must be ≥1.
- SYNC_POL, 0: sync active level (0 = active-low).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- en  input  1  scan enable
- pixel_x  output  10  current horizontal counter, to PMEM
- pixel_y  output  10  current vertical counter, to PMEM
- rgb_in  input  12  colour from PMEM for (pixel_x, pixel_y): {R[11:8], G[7:4], B[3:0]}
- vga_r  output  4  red
- vga_g  output  4  green
- vga_b  output  4  blue
- vga_hs  output  1  horizontal sync
- vga_vs  output  1  vertical sync
- visible  output  1  high while the registered colour belongs to the active area
- frame_start  output  1  one-clk pulse when pixel (0,0) is presented at the pins

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP, both ≤ 1024.
- Reset (rst=0, asynchronous): all counters, pixel_x, pixel_y, vga_r/g/b, visible and frame_start go to 0. vga_hs and vga_vs go to the inactive level (~SYNC_POL). Scanning restarts at (0,0) on the first tick after release. Reset mid-frame behaves identically.
- Pixel tick:
  - div_cnt counts 0..PIX_DIV-1 while en=1.
  - tick = (div_cnt == PIX_DIV-1).
  - PIX_DIV=1 gives tick every cycle.
- Counters: pixel_x and pixel_y are the raw h_cnt and v_cnt registers, including in blanking. On tick:
  - h_cnt increments, wrapping H_TOTAL-1 → 0.
  - On that wrap, v_cnt increments, wrapping V_TOTAL-1 → 0.
  - Both wrap on the same tick at (H_TOTAL-1, V_TOTAL-1).
- Output stage: on a tick, before the counters advance, the following are registered from the current h_cnt/v_cnt:
  - act = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - {vga_r, vga_g, vga_b} ← act ? rgb_in : 0.
  - visible ← act.
  - vga_hs ← SYNC_POL when H_VISIBLE+H_FP ≤ h_cnt < H_VISIBLE+H_FP+H_SYNC, else ~SYNC_POL.
  - vga_vs ← SYNC_POL when V_VISIBLE+V_FP ≤ v_cnt < V_VISIBLE+V_FP+V_SYNC, else ~SYNC_POL. vga_vs is based on v_cnt only.
  - frame_start ← (h_cnt==0 && v_cnt==0). It is high for exactly one clk, the cycle following that tick.
- Latency:
  - rgb_in must be valid combinationally within the cycle after pixel_x/pixel_y change.
  - Pin outputs lag the counters by exactly one pixel tick.
  - Outputs change only on tick edges, except frame_start, which clears the next clk.
- en=0, synchronous:
  - div_cnt, h_cnt and v_cnt are cleared to 0.
  - Colour, visible and frame_start are cleared to 0.
  - Syncs are held inactive.
  - After en rises, the first tick occurs PIX_DIV cycles later, at (0,0).
- rgb_in changes during blanking have no effect on the pins.

Test Plan:
Directed tests use H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), PIX_DIV=2 and SYNC_POL=0, unless stated otherwise.
- Reset: hold rst=0 while en=1 and rgb_in=0xFFF → all colour outputs, visible, pixel_x, pixel_y and frame_start are 0, and vga_hs=vga_vs=1. Release → pixel_x steps 0,1,2… every 2 clk.
- Line timing: en=1, rgb_in=0xABC → vga_r/g/b = A/B/C for 8 ticks, then 0 for 6 ticks. vga_hs=0 for exactly 3 ticks, starting the tick after the one at pixel_x=10. The pattern repeats every 28 clk.
- Frame timing:
  - vga_vs=0 for exactly 2 lines (56 clk).
  - frame_start pulses once per 8×28 = 224 clk and is 1 clk wide.
  - visible is high for 4×8 = 32 ticks per frame.
- Wrap: pixel_x goes 13→0 while pixel_y goes 7→0 on the same tick, and frame_start follows one tick later.
- Enable drop mid-line at pixel_x=5, pixel_y=2 → the next clk has counters at 0, colours 0 and syncs high. Re-enable → first advance after 2 clk, and the colour of (0,0) appears at the pins.
- Async reset mid-frame (pixel_y=3), asserted between clk edges → outputs reach reset values with no clk edge. Default parameters, PIX_DIV=4: frame_start period = 800×525×4 = 1,680,000 clk.
